// File: rtl/cim_pkg.sv
// cim_pkg: shared FSM state, accumulator sizing and writeback clipping for the CIM tile.
package cim_pkg;
  typedef enum logic [1:0] {IDLE, COMPUTE, WRITEBACK} cim_state_e;
  function automatic int cim_acc_width(input int dsz, input int xsz);
    return 2 * dsz + $clog2(xsz);
  endfunction
  function automatic logic [63:0] cim_sat_shift(input logic [63:0] acc, input int shift, input int dsz);
    logic [63:0] s;
    logic [63:0] m;
    s = acc >> shift;
    m = (64'd1 << dsz) - 64'd1;
    return (s > m) ? m : s;
  endfunction
endpackage

// File: rtl/cim_xbar_tile_col_acc.sv
// cim_col_acc: one crossbar column accumulator with clear and multiply-add enable.
module cim_col_acc #(
  parameter int dw = 2,
  parameter int aw = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [dw-1:0] a_i,
  input  logic [dw-1:0] b_i,
  output logic [aw-1:0] acc_o
);
  logic [aw-1:0] acc_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) acc_q <= '0;
    else if (clr_i) acc_q <= '0;
    else if (en_i) acc_q <= acc_q + aw'(a_i) * aw'(b_i);
  assign acc_o = acc_q;
endmodule

// File: rtl/cim_xbar_tile.sv
// cim_xbar_tile: CIM crossbar tile; stores inputs and weights, computes a matrix-vector
// product one row per cycle and publishes clipped column results to a read buffer.
module cim_xbar_tile
  import cim_pkg::*;
#(
  parameter int xbar_size     = 256,
  parameter int datatype_size = 2,
  parameter int out_shift     = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_we,
  input  logic [$clog2(xbar_size)-1:0] i_wr_addr,
  input  logic [datatype_size-1:0]     i_wr_data,
  input  logic                         i_wgt_we,
  input  logic [$clog2(xbar_size)-1:0] i_wgt_row,
  input  logic [$clog2(xbar_size)-1:0] i_wgt_col,
  input  logic [datatype_size-1:0]     i_wgt_data,
  input  logic                         i_start,
  output logic                         o_busy,
  output logic                         o_wr_drop,
  input  logic [$clog2(xbar_size)-1:0] i_rd_addr,
  output logic [datatype_size-1:0]     o_rd_data
);
  localparam int aw   = $clog2(xbar_size);
  localparam int dw   = datatype_size;
  localparam int accw = cim_acc_width(datatype_size, xbar_size);
  cim_state_e                   state_q;
  logic [aw-1:0]                row_q;
  logic                         busy_q, drop_q, drop_d, start_ok;
  logic [dw-1:0]                rd_q;
  logic [xbar_size-1:0][dw-1:0] ibuf_q, obuf_q;
  logic [xbar_size-1:0][dw-1:0] w_q [xbar_size];
  logic [accw-1:0]              acc [xbar_size];
  assign start_ok = (state_q == IDLE) && i_start;
  assign drop_d   = busy_q && (i_we || i_wgt_we || i_start);
  for (genvar c = 0; c < xbar_size; c++) begin : g_col
    cim_col_acc #(.dw(dw), .aw(accw)) u_acc (
      .clk(clk), .rst(rst), .clr_i(start_ok), .en_i(state_q == COMPUTE),
      .a_i(ibuf_q[row_q]), .b_i(w_q[row_q][c]), .acc_o(acc[c])
    );
  end
  // obuf changes only in WRITEBACK, so reads during COMPUTE see the previous result
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
      rd_q    <= '0;
      ibuf_q  <= '0;
      obuf_q  <= '0;
      for (int r = 0; r < xbar_size; r++) w_q[r] <= '0;
    end else begin
      drop_q <= drop_d;
      rd_q   <= obuf_q[i_rd_addr];
      case (state_q)
        IDLE: begin
          if (i_we) ibuf_q[i_wr_addr] <= i_wr_data;
          if (i_wgt_we) w_q[i_wgt_row][i_wgt_col] <= i_wgt_data;
          if (i_start) begin
            state_q <= COMPUTE;
            row_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        COMPUTE: begin
          row_q <= row_q + 1'b1;
          if (row_q == aw'(xbar_size - 1)) state_q <= WRITEBACK;
        end
        WRITEBACK: begin
          for (int k = 0; k < xbar_size; k++) obuf_q[k] <= dw'(cim_sat_shift(64'(acc[k]), out_shift, dw));
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign o_busy    = busy_q;
  assign o_wr_drop = drop_q;
  assign o_rd_data = rd_q;
endmodule

// File: tb/tb_cim_xbar_tile.sv
// tb_cim_xbar_tile: directed and randomized checks of two tiles (out_shift 0 and 5) against an arithmetic model.
module tb_cim_xbar_tile;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_we = 1'b0, i_wgt_we = 1'b0, i_start = 1'b0;
  logic [2:0] i_wr_addr = '0, i_wgt_row = '0, i_wgt_col = '0, i_rd_addr = '0;
  logic [1:0] i_wr_data = '0, i_wgt_data = '0;
  logic       busy0, drop0, busy5, drop5;
  logic [1:0] rd0, rd5;
  int checks = 0, failures = 0;
  int ibuf_m [8];
  int w_m [8][8];
  int ob0 [8];
  int ob5 [8];

  always #5 clk = ~clk;

  cim_xbar_tile #(.xbar_size(8), .datatype_size(2), .out_shift(0)) dut0 (
    .clk(clk), .rst(rst), .i_we(i_we), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_wgt_we(i_wgt_we), .i_wgt_row(i_wgt_row), .i_wgt_col(i_wgt_col), .i_wgt_data(i_wgt_data),
    .i_start(i_start), .o_busy(busy0), .o_wr_drop(drop0), .i_rd_addr(i_rd_addr), .o_rd_data(rd0));
  cim_xbar_tile #(.xbar_size(8), .datatype_size(2), .out_shift(5)) dut5 (
    .clk(clk), .rst(rst), .i_we(i_we), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_wgt_we(i_wgt_we), .i_wgt_row(i_wgt_row), .i_wgt_col(i_wgt_col), .i_wgt_data(i_wgt_data),
    .i_start(i_start), .o_busy(busy5), .o_wr_drop(drop5), .i_rd_addr(i_rd_addr), .o_rd_data(rd5));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic void model_compute;
    for (int c = 0; c < 8; c++) begin
      int acc = 0;
      for (int r = 0; r < 8; r++) acc += ibuf_m[r] * w_m[r][c];
      ob0[c] = acc > 3 ? 3 : acc;
      ob5[c] = (acc >> 5) > 3 ? 3 : (acc >> 5);
    end
  endfunction

  task automatic wr_in(input int a, input int d);
    i_we = 1'b1; i_wr_addr = 3'(a); i_wr_data = 2'(d);
    step;
    i_we = 1'b0;
    ibuf_m[a] = d;
  endtask

  task automatic wgt(input int r, input int c, input int d);
    i_wgt_we = 1'b1; i_wgt_row = 3'(r); i_wgt_col = 3'(c); i_wgt_data = 2'(d);
    step;
    i_wgt_we = 1'b0;
    w_m[r][c] = d;
  endtask

  task automatic read_all;
    for (int c = 0; c < 8; c++) begin
      i_rd_addr = 3'(c);
      step;
      chk("rd_col_s0", rd0, ob0[c]);
      chk("rd_col_s5", rd5, ob5[c]);
    end
  endtask

  // we_k/st_k: cycle after start on which a (dropped) write or start strobe is issued, 0 = none
  task automatic compute(input int ra, input int we_k, input int st_k, input bit sw, input int sw_a, input int sw_d);
    int old0, old5, new0, new5;
    i_rd_addr = 3'(ra);
    i_start = 1'b1;
    if (sw) begin
      i_we = 1'b1; i_wr_addr = 3'(sw_a); i_wr_data = 2'(sw_d);
      ibuf_m[sw_a] = sw_d;
    end
    old0 = ob0[ra]; old5 = ob5[ra];
    model_compute();
    new0 = ob0[ra]; new5 = ob5[ra];
    for (int j = 1; j <= 11; j++) begin
      step;
      i_start = 1'b0; i_we = 1'b0;
      chk("busy_s0", busy0, 32'(j <= 9));
      chk("busy_s5", busy5, 32'(j <= 9));
      chk("drop", drop0, 32'((we_k > 0 && j - 1 == we_k) || (st_k > 0 && j - 1 == st_k)));
      chk("rd_during_s0", rd0, j <= 10 ? old0 : new0);
      chk("rd_during_s5", rd5, j <= 10 ? old5 : new5);
      if (j == we_k) begin
        i_we = 1'b1; i_wr_addr = 3'd0; i_wr_data = 2'd3;
      end
      if (j == st_k) i_start = 1'b1;
    end
  endtask

  task automatic random_load;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) wgt(r, c, int'($urandom_range(3, 0)));
    for (int r = 0; r < 8; r++) wr_in(r, int'($urandom_range(3, 0)));
  endtask

  initial begin
    for (int r = 0; r < 8; r++) begin
      ibuf_m[r] = 0; ob0[r] = 0; ob5[r] = 0;
      for (int c = 0; c < 8; c++) w_m[r][c] = 0;
    end
    repeat (2) step;
    chk("reset_busy", busy0, 0);
    chk("reset_drop", drop0, 0);
    chk("reset_rd_s0", rd0, 0);
    chk("reset_rd_s5", rd5, 0);
    rst = 1'b1;
    step;
    random_load();
    compute(3, 0, 0, 1'b0, 0, 0);
    read_all();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) wgt(r, c, r == c ? 1 : 0);
    for (int r = 0; r < 8; r++) wr_in(r, r < 4 ? r : 7 - r);
    compute(0, 0, 0, 1'b0, 0, 0);
    read_all();
    compute(0, 3, 5, 1'b0, 0, 0);
    read_all();
    compute(0, 0, 0, 1'b0, 0, 0);
    read_all();
    wr_in(2, 1);
    compute(2, 0, 1, 1'b0, 0, 0);
    read_all();
    for (int r = 0; r < 8; r++) wr_in(r, 0);
    wgt(7, 0, 1);
    compute(0, 0, 0, 1'b1, 7, 1);
    read_all();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) wgt(r, c, 3);
    for (int r = 0; r < 8; r++) wr_in(r, 3);
    compute(5, 0, 0, 1'b0, 0, 0);
    read_all();
    i_start = 1'b1;
    step;
    i_start = 1'b0;
    repeat (3) step;
    #3 rst = 1'b0;
    #1;
    chk("midreset_busy", busy0, 0);
    chk("midreset_drop", drop0, 0);
    chk("midreset_rd_s0", rd0, 0);
    chk("midreset_rd_s5", rd5, 0);
    #2 rst = 1'b1;
    for (int r = 0; r < 8; r++) begin
      ibuf_m[r] = 0; ob0[r] = 0; ob5[r] = 0;
      for (int c = 0; c < 8; c++) w_m[r][c] = 0;
    end
    step;
    read_all();
    random_load();
    compute(6, 0, 0, 1'b0, 0, 0);
    read_all();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
